// File: rtl/axppa_error_monitor.sv
// axppa_error_monitor
//   Scores an approximate WIDTH-bit adder against the exact sum over a
//   programmed run of n_samples tuples. It reports the sample count, the
//   number of wrong sums, the sum of error distances and the largest error
//   distance seen.
//
//   Pipeline: S1 captures the accepted tuple. S2 computes the exact sum, the
//   error distance and the mismatch mask. S3 folds these into the statistics.
//
//   Valid/ready: a tuple transfers on a rising edge where in_valid and
//   in_ready are both high. in_ready depends only on the FSM state and the
//   accept count, never on in_valid. A producer may therefore hold in_valid
//   high and simply wait for in_ready.
//
//   Optional feature: define AXPPA_ERR_BITPOS_EN to add WIDTH per-bit mismatch
//   counters. They appear on bit_err_cnt, flattened LSB-first.
module axppa_error_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       n_samples,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic                   in_cin,
    input  logic [WIDTH-1:0]       in_sum,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       sample_cnt,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [ACC_W-1:0]       ed_sum,
    output logic [WIDTH-1:0]       ed_max
`ifdef AXPPA_ERR_BITPOS_EN
    ,
    output logic [WIDTH*CNT_W-1:0] bit_err_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] accepted;

    logic             start_ok;
    logic             accept;

    // S1 registers
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    logic [WIDTH-1:0] s1_sum;

    // S2 combinational results and registers
    logic [WIDTH-1:0] exact;
    logic [WIDTH-1:0] ed_c;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_ed;

    // S3 helper for the saturating distance accumulator
    logic [ACC_W:0]   ed_sum_nxt;

    // Start is only meaningful between runs; during RUN/DRAIN it is dropped.
    assign start_ok = start & ((state == ST_IDLE) | (state == ST_DONE));

    // Ready while running and the programmed sample count is not yet reached.
    assign in_ready = (state == ST_RUN) & (accepted < n_q);
    assign accept   = in_valid & in_ready;

    // Run-control FSM with registered busy/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            n_q      <= '0;
            accepted <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        n_q      <= n_samples;
                        accepted <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        accepted <= accepted + CNT_ONE;
                    end
                    // accepted only reaches n_q after the last accept edge, so
                    // no tuple can be lost on this transition.
                    if (accepted == n_q) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Once S1 and S2 are empty, the final S3 update has landed.
                    if (!s1_valid && !s2_valid) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // S1: capture the accepted operand/sum tuple.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
            s1_sum   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_cin <= in_cin;
                s1_sum <= in_sum;
            end
        end
    end

    // S2 math: exact sum modulo 2^WIDTH (carry-out dropped) and |exact - sum|.
    always_comb begin
        exact = s1_a + s1_b + {{(WIDTH-1){1'b0}}, s1_cin};
        if (exact >= s1_sum) begin
            ed_c = exact - s1_sum;
        end else begin
            ed_c = s1_sum - exact;
        end
    end

    // S2: register the error distance for the statistics stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_ed    <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_ed <= ed_c;
            end
        end
    end

    // One extra bit to detect overflow of the distance accumulator.
    assign ed_sum_nxt = {1'b0, ed_sum} + {{(ACC_W+1-WIDTH){1'b0}}, s2_ed};

    // S3: saturating statistics; an honoured start clears them for the new run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            ed_sum     <= '0;
            ed_max     <= '0;
        end else if (start_ok) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            ed_sum     <= '0;
            ed_max     <= '0;
        end else if (s2_valid) begin
            if (sample_cnt != CNT_MAX) begin
                sample_cnt <= sample_cnt + CNT_ONE;
            end
            if ((s2_ed != '0) && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
            if (ed_sum_nxt[ACC_W]) begin
                ed_sum <= ACC_MAX;
            end else begin
                ed_sum <= ed_sum_nxt[ACC_W-1:0];
            end
            if (s2_ed > ed_max) begin
                ed_max <= s2_ed;
            end
        end
    end

`ifdef AXPPA_ERR_BITPOS_EN
    logic [WIDTH-1:0] s2_mis;
    logic [CNT_W-1:0] bit_cnt [WIDTH];

    // S2: register which bit positions of the approximate sum are wrong.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_mis <= '0;
        end else if (s1_valid) begin
            s2_mis <= exact ^ s1_sum;
        end
    end

    // S3: saturating per-bit mismatch counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < WIDTH; k++) begin
                bit_cnt[k] <= '0;
            end
        end else if (start_ok) begin
            for (int k = 0; k < WIDTH; k++) begin
                bit_cnt[k] <= '0;
            end
        end else if (s2_valid) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (s2_mis[k] && (bit_cnt[k] != CNT_MAX)) begin
                    bit_cnt[k] <= bit_cnt[k] + CNT_ONE;
                end
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit_flat
        assign bit_err_cnt[g*CNT_W +: CNT_W] = bit_cnt[g];
    end
`endif

endmodule

// File: tb/tb_axppa_error_monitor.sv
// Directed bench for axppa_error_monitor. Each scenario task drives its own
// stimulus and checks its outcome against hand-computed values.
module tb_axppa_error_monitor;

    localparam int WIDTH = 16;
    localparam int CNT_W = 32;
    localparam int ACC_W = 48;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] n_samples;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [WIDTH-1:0] in_sum;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [ACC_W-1:0] ed_sum;
    logic [WIDTH-1:0] ed_max;
`ifdef AXPPA_ERR_BITPOS_EN
    logic [WIDTH*CNT_W-1:0] bit_err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    axppa_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n_samples  (n_samples),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .in_sum     (in_sum),
        .busy       (busy),
        .done       (done),
        .sample_cnt (sample_cnt),
        .err_cnt    (err_cnt),
        .ed_sum     (ed_sum),
        .ed_max     (ed_max)
`ifdef AXPPA_ERR_BITPOS_EN
        ,
        .bit_err_cnt(bit_err_cnt)
`endif
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    // Called on a falling edge; start is seen by the following rising edge.
    task automatic pulse_start(input logic [CNT_W-1:0] n);
        start     = 1'b1;
        n_samples = n;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Present one tuple and hold it until accepted (bounded wait).
    task automatic send_tuple(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic c, input logic [WIDTH-1:0] s, output bit ok);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        in_sum   = s;
        ok       = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Wait on falling edges for done, at most max_cyc cycles.
    task automatic wait_done(input int max_cyc, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (done) begin
                ok  = 1'b1;
                cyc = i;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (sample_cnt !== '0) begin n_bad++; $display("FAIL reset_sample_cnt got=%0d exp=0", sample_cnt); end
        n_cmp++; if (err_cnt !== '0) begin n_bad++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        n_cmp++; if (ed_sum !== '0) begin n_bad++; $display("FAIL reset_ed_sum got=%0d exp=0", ed_sum); end
        n_cmp++; if (ed_max !== '0) begin n_bad++; $display("FAIL reset_ed_max got=%0d exp=0", ed_max); end
`ifdef AXPPA_ERR_BITPOS_EN
        n_cmp++; if (bit_err_cnt !== '0) begin n_bad++; $display("FAIL reset_bit_err_cnt got=%h exp=0", bit_err_cnt); end
`endif
    endtask

    task automatic test_exact_run;
        bit ok;
        int cyc;
        logic [WIDTH-1:0] va [4] = '{16'h1234, 16'hFFFF, 16'hA5A5, 16'h7FFF};
        logic [WIDTH-1:0] vb [4] = '{16'h0001, 16'h0001, 16'h5A5A, 16'h0001};
        logic             vc [4] = '{1'b1,     1'b0,     1'b1,     1'b0};
        logic [WIDTH-1:0] vs [4] = '{16'h1236, 16'h0000, 16'h0000, 16'h8000};
        pulse_start(4);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL exact_busy got=%b exp=1", busy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL exact_ready got=%b exp=1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            send_tuple(va[i], vb[i], vc[i], vs[i], ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL exact_accept%0d got=timeout exp=accept", i); end
        end
        wait_done(20, ok, cyc);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL exact_done got=timeout exp=done"); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL exact_busy_end got=%b exp=0", busy); end
        n_cmp++; if (sample_cnt !== 32'd4) begin n_bad++; $display("FAIL exact_sample_cnt got=%0d exp=4", sample_cnt); end
        n_cmp++; if (err_cnt !== 32'd0) begin n_bad++; $display("FAIL exact_err_cnt got=%0d exp=0", err_cnt); end
        n_cmp++; if (ed_sum !== 48'd0) begin n_bad++; $display("FAIL exact_ed_sum got=%0d exp=0", ed_sum); end
        n_cmp++; if (ed_max !== 16'd0) begin n_bad++; $display("FAIL exact_ed_max got=%0d exp=0", ed_max); end
    endtask

    task automatic test_error_metrics;
        bit ok;
        int cyc;
        pulse_start(2);
        // exact 0x0100 vs 0x0000 -> ed 256, bit 8 wrong
        send_tuple(16'h00FF, 16'h0001, 1'b0, 16'h0000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL err_accept0 got=timeout exp=accept"); end
        // exact 0x0001 (carry-out dropped) vs 0x0003 -> ed 2, bit 1 wrong
        send_tuple(16'h8000, 16'h8000, 1'b1, 16'h0003, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL err_accept1 got=timeout exp=accept"); end
        wait_done(20, ok, cyc);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL err_done got=timeout exp=done"); end
        n_cmp++; if (sample_cnt !== 32'd2) begin n_bad++; $display("FAIL err_sample_cnt got=%0d exp=2", sample_cnt); end
        n_cmp++; if (err_cnt !== 32'd2) begin n_bad++; $display("FAIL err_err_cnt got=%0d exp=2", err_cnt); end
        n_cmp++; if (ed_sum !== 48'd258) begin n_bad++; $display("FAIL err_ed_sum got=%0d exp=258", ed_sum); end
        n_cmp++; if (ed_max !== 16'd256) begin n_bad++; $display("FAIL err_ed_max got=%0d exp=256", ed_max); end
`ifdef AXPPA_ERR_BITPOS_EN
        for (int k = 0; k < WIDTH; k++) begin
            logic [CNT_W-1:0] exp_b;
            exp_b = (k == 8 || k == 1) ? 32'd1 : 32'd0;
            n_cmp++;
            if (bit_err_cnt[k*CNT_W +: CNT_W] !== exp_b) begin
                n_bad++;
                $display("FAIL err_bit%0d got=%0d exp=%0d", k, bit_err_cnt[k*CNT_W +: CNT_W], exp_b);
            end
        end
`endif
    endtask

    task automatic test_backpressure;
        bit ok;
        int cyc;
        int accepts;
        logic [9:0] ready_seen;
        pulse_start(3);
        accepts    = 0;
        ready_seen = '0;
        in_valid   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_a   = WIDTH'(i);
            in_b   = 16'h0001;
            in_cin = 1'b0;
            in_sum = WIDTH'(i + 1);
            ready_seen[i] = in_ready;
            if (in_ready) accepts++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_cmp++; if (accepts != 3) begin n_bad++; $display("FAIL bp_accepts got=%0d exp=3", accepts); end
        n_cmp++; if (ready_seen !== 10'b00_0000_0111) begin n_bad++; $display("FAIL bp_ready_pattern got=%b exp=0000000111", ready_seen); end
        wait_done(20, ok, cyc);
        if (!done) begin
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_done got=timeout exp=done"); end
        end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL bp_done_flag got=%b exp=1", done); end
        n_cmp++; if (sample_cnt !== 32'd3) begin n_bad++; $display("FAIL bp_sample_cnt got=%0d exp=3", sample_cnt); end
        n_cmp++; if (err_cnt !== 32'd0) begin n_bad++; $display("FAIL bp_err_cnt got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_zero_samples;
        bit ok;
        int cyc;
        pulse_start(0);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL zero_ready got=%b exp=0", in_ready); end
        wait_done(3, ok, cyc);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL zero_done got=timeout exp=done_within_3"); end
        n_cmp++; if (sample_cnt !== 32'd0) begin n_bad++; $display("FAIL zero_sample_cnt got=%0d exp=0", sample_cnt); end
        n_cmp++; if (ed_sum !== 48'd0) begin n_bad++; $display("FAIL zero_ed_sum got=%0d exp=0", ed_sum); end
    endtask

    task automatic test_start_ignored;
        bit ok;
        int cyc;
        pulse_start(2);
        send_tuple(16'h0010, 16'h0020, 1'b0, 16'h0031, ok); // exact 0x0030, ed 1
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL ign_accept0 got=timeout exp=accept"); end
        // Second start mid-run with a different count must not relatch or clear.
        pulse_start(5);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ign_busy got=%b exp=1", busy); end
        send_tuple(16'h0100, 16'h0200, 1'b1, 16'h0301, ok); // exact, ed 0
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL ign_accept1 got=timeout exp=accept"); end
        wait_done(20, ok, cyc);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL ign_done got=timeout exp=done"); end
        n_cmp++; if (sample_cnt !== 32'd2) begin n_bad++; $display("FAIL ign_sample_cnt got=%0d exp=2", sample_cnt); end
        n_cmp++; if (err_cnt !== 32'd1) begin n_bad++; $display("FAIL ign_err_cnt got=%0d exp=1", err_cnt); end
        n_cmp++; if (ed_sum !== 48'd1) begin n_bad++; $display("FAIL ign_ed_sum got=%0d exp=1", ed_sum); end
    endtask

    task automatic test_reset_mid_run;
        bit ok;
        pulse_start(5);
        send_tuple(16'h0001, 16'h0001, 1'b0, 16'h0005, ok); // ed 3
        send_tuple(16'h0002, 16'h0002, 1'b0, 16'h0004, ok); // exact
        repeat (3) @(negedge clk);
        n_cmp++; if (sample_cnt !== 32'd2) begin n_bad++; $display("FAIL mid_pre_sample_cnt got=%0d exp=2", sample_cnt); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
        n_cmp++; if (sample_cnt !== 32'd0) begin n_bad++; $display("FAIL mid_sample_cnt got=%0d exp=0", sample_cnt); end
        n_cmp++; if (ed_sum !== 48'd0) begin n_bad++; $display("FAIL mid_ed_sum got=%0d exp=0", ed_sum); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready got=%b exp=0", in_ready); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mid_done got=%b exp=0", done); end
        n_cmp++; if (ed_max !== 16'd0) begin n_bad++; $display("FAIL mid_ed_max got=%0d exp=0", ed_max); end
    endtask

    task automatic test_restart;
        bit ok;
        int cyc;
        // Leave a DONE state with nonzero statistics first.
        pulse_start(1);
        send_tuple(16'h0000, 16'h0000, 1'b0, 16'h0040, ok); // ed 64
        wait_done(20, ok, cyc);
        n_cmp++; if (ed_max !== 16'd64) begin n_bad++; $display("FAIL rs_pre_ed_max got=%0d exp=64", ed_max); end
        pulse_start(1);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rs_done_cleared got=%b exp=0", done); end
        n_cmp++; if (ed_max !== 16'd0) begin n_bad++; $display("FAIL rs_cleared_ed_max got=%0d exp=0", ed_max); end
        send_tuple(16'h4000, 16'h0001, 1'b1, 16'h4002, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rs_accept got=timeout exp=accept"); end
        wait_done(20, ok, cyc);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rs_done got=timeout exp=done"); end
        n_cmp++; if (sample_cnt !== 32'd1) begin n_bad++; $display("FAIL rs_sample_cnt got=%0d exp=1", sample_cnt); end
        n_cmp++; if (err_cnt !== 32'd0) begin n_bad++; $display("FAIL rs_err_cnt got=%0d exp=0", err_cnt); end
        n_cmp++; if (ed_sum !== 48'd0) begin n_bad++; $display("FAIL rs_ed_sum got=%0d exp=0", ed_sum); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        n_samples = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sum    = '0;
        @(negedge clk);
        test_reset();
        test_exact_run();
        test_error_metrics();
        test_backpressure();
        test_zero_samples();
        test_start_ignored();
        test_reset_mid_run();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
